// File: rtl/demux_router_pkg.sv
// Shared types and constants for demux_router: packet-lock state and drop counter width.
package demux_router_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } lock_state_e;

  localparam int DROP_CNT_W = 16;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] value);
    return (&value) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry register slice with valid/ready; holds one beat per output channel.
module demux_slot #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_last,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_last
);

  // A load may coincide with a drain, giving one beat per cycle.
  assign wr_ready = ~rd_valid | rd_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_last  <= 1'b0;
    end else if (wr_valid && wr_ready) begin
      rd_valid <= 1'b1;
      rd_data  <= wr_data;
      rd_last  <= wr_last;
    end else if (rd_ready) begin
      rd_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_router.sv
// Routes input beats to one of N registered output channels; out-of-range beats are dropped
// and counted. Define DEMUX_ROUTER_PKT_LOCK_EN to route whole packets by their first beat.
module demux_router
  import demux_router_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic [WIDTH-1:0]      s_data_i,
  input  logic [$clog2(N)-1:0]  s_sel_i,
  input  logic                  s_last_i,
  output logic [N-1:0]          m_valid_o,
  input  logic [N-1:0]          m_ready_i,
  output logic [WIDTH-1:0]      m_data_o [N],
  output logic [N-1:0]          m_last_o,
  output logic                  err_o,
  output logic [DROP_CNT_W-1:0] drop_cnt_o
);

  localparam int SEL_W = $clog2(N);

  logic [SEL_W-1:0]      dest;
  logic                  dest_oor;
  logic                  sel_ready;
  logic                  accept;
  logic                  drop;
  logic [N-1:0]          slot_ready;
  logic [N-1:0]          slot_load;
  logic [DROP_CNT_W-1:0] drop_cnt;

`ifdef DEMUX_ROUTER_PKT_LOCK_EN
  lock_state_e      state;
  lock_state_e      state_next;
  logic [SEL_W-1:0] lock_dest;
  logic [SEL_W-1:0] lock_dest_next;

  // Once a packet is open, its first beat's destination (even an invalid one) wins.
  assign dest = (state == LOCKED) ? lock_dest : s_sel_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      lock_dest <= '0;
    end else begin
      state     <= state_next;
      lock_dest <= lock_dest_next;
    end
  end

  always_comb begin
    state_next     = state;
    lock_dest_next = lock_dest;
    case (state)
      IDLE: begin
        if (accept && !s_last_i) begin
          state_next     = LOCKED;
          lock_dest_next = s_sel_i;
        end
      end
      LOCKED: begin
        if (accept && s_last_i) begin
          state_next = IDLE;
        end
      end
    endcase
  end
`else
  assign dest = s_sel_i;
`endif

  assign dest_oor = (int'(dest) >= N);

  // Ready depends only on the addressed slot, so a stalled channel never blocks others.
  always_comb begin
    sel_ready = 1'b1;
    slot_load = '0;
    for (int i = 0; i < N; i++) begin
      if (int'(dest) == i) begin
        sel_ready    = slot_ready[i];
        slot_load[i] = s_valid_i;
      end
    end
  end

  assign s_ready_o = sel_ready;
  assign accept    = s_valid_i & s_ready_o;
  assign drop      = accept & dest_oor;

  for (genvar g = 0; g < N; g++) begin : g_slot
    demux_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk      (clk_i),
      .rst      (rst_i),
      .wr_valid (slot_load[g]),
      .wr_ready (slot_ready[g]),
      .wr_data  (s_data_i),
      .wr_last  (s_last_i),
      .rd_valid (m_valid_o[g]),
      .rd_ready (m_ready_i[g]),
      .rd_data  (m_data_o[g]),
      .rd_last  (m_last_o[g])
    );
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_o    <= 1'b0;
      drop_cnt <= '0;
    end else begin
      err_o <= drop;
      if (drop) begin
        drop_cnt <= sat_inc(drop_cnt);
      end
    end
  end

  assign drop_cnt_o = drop_cnt;

endmodule

// File: tb/tb_demux_router.sv
// Bench for demux_router: random traffic on an N=3 instance against a reference model,
// plus directed scenarios on an N=4 instance.
module tb_demux_router;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Instance A: N=3, so sel=3 is out of range.
  logic           a_valid, a_ready, a_last, a_err;
  logic [W-1:0]   a_data;
  logic [1:0]     a_sel;
  logic [2:0]     a_mvalid, a_mready, a_mlast;
  logic [W-1:0]   a_mdata [3];
  logic [15:0]    a_cnt;

  // Instance B: N=4, every sel is in range.
  logic           b_valid, b_ready, b_last, b_err;
  logic [W-1:0]   b_data;
  logic [1:0]     b_sel;
  logic [3:0]     b_mvalid, b_mready, b_mlast;
  logic [W-1:0]   b_mdata [4];
  logic [15:0]    b_cnt;

  demux_router #(.WIDTH(W), .N(3)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .s_valid_i(a_valid), .s_ready_o(a_ready),
    .s_data_i(a_data), .s_sel_i(a_sel), .s_last_i(a_last),
    .m_valid_o(a_mvalid), .m_ready_i(a_mready), .m_data_o(a_mdata),
    .m_last_o(a_mlast), .err_o(a_err), .drop_cnt_o(a_cnt)
  );

  demux_router #(.WIDTH(W), .N(4)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .s_valid_i(b_valid), .s_ready_o(b_ready),
    .s_data_i(b_data), .s_sel_i(b_sel), .s_last_i(b_last),
    .m_valid_o(b_mvalid), .m_ready_i(b_mready), .m_data_o(b_mdata),
    .m_last_o(b_mlast), .err_o(b_err), .drop_cnt_o(b_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model for instance A: per-channel occupancy and contents.
  logic [2:0]   e_valid;
  logic [W-1:0] e_data [3];
  logic [2:0]   e_last;
  logic         e_err;
  logic [15:0]  e_cnt;
  bit           e_locked;
  logic [1:0]   e_ldest;
  int           md;
  bit           m_rdy;
  bit           m_acc;

  always @(negedge clk) begin
    if (rst) begin
      check("rst_m_valid", a_mvalid, 3'b000);
      check("rst_m_last", a_mlast, 3'b000);
      check("rst_err", a_err, 1'b0);
      check("rst_drop_cnt", a_cnt, 16'h0);
      for (int c = 0; c < 3; c++) check("rst_m_data", a_mdata[c], '0);
      e_valid  = '0;
      e_last   = '0;
      e_err    = 1'b0;
      e_cnt    = '0;
      e_locked = 1'b0;
      e_ldest  = '0;
      for (int c = 0; c < 3; c++) e_data[c] = '0;
    end else begin
      md    = e_locked ? int'(e_ldest) : int'(a_sel);
      m_rdy = (md >= 3) ? 1'b1 : (!e_valid[md] || a_mready[md]);
      check("s_ready", a_ready, m_rdy);
      check("m_valid", a_mvalid, e_valid);
      for (int c = 0; c < 3; c++) begin
        if (e_valid[c]) begin
          check("m_data", a_mdata[c], e_data[c]);
          check("m_last", a_mlast[c], e_last[c]);
        end
      end
      check("err", a_err, e_err);
      check("drop_cnt", a_cnt, e_cnt);
      m_acc = a_valid && m_rdy;
      for (int c = 0; c < 3; c++) begin
        if (m_acc && md == c) begin
          e_valid[c] = 1'b1;
          e_data[c]  = a_data;
          e_last[c]  = a_last;
        end else if (e_valid[c] && a_mready[c]) begin
          e_valid[c] = 1'b0;
        end
      end
      e_err = m_acc && (md >= 3);
      if (e_err && e_cnt != 16'hFFFF) e_cnt = e_cnt + 16'd1;
`ifdef DEMUX_ROUTER_PKT_LOCK_EN
      if (m_acc) begin
        if (!e_locked && !a_last) begin
          e_locked = 1'b1;
          e_ldest  = a_sel;
        end else if (e_locked && a_last) begin
          e_locked = 1'b0;
        end
      end
`endif
    end
  end

  initial begin
    rst = 1'b1;
    a_valid = 0; a_data = '0; a_sel = '0; a_last = 0; a_mready = 3'b111;
    b_valid = 0; b_data = '0; b_sel = '0; b_last = 0; b_mready = 4'hF;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("b_reset_valid", b_mvalid, 4'b0000);
    check("b_reset_cnt", b_cnt, 16'h0);
    check("b_reset_err", b_err, 1'b0);

    // Single beat to ch2 appears there one cycle later.
    b_valid = 1; b_sel = 2; b_data = 32'hA5A5A5A5; b_last = 1;
    #1 check("b_ready_ch2", b_ready, 1'b1);
    @(posedge clk); #1 b_valid = 0;
    check("b_ch2_valid", b_mvalid, 4'b0100);
    check("b_ch2_data", b_mdata[2], 32'hA5A5A5A5);
    @(posedge clk); #1 check("b_ch2_drained", b_mvalid, 4'b0000);

    // Blocked ch1 stalls a second ch1 beat but not a following ch3 beat.
    b_mready = 4'b1101;
    b_valid = 1; b_sel = 1; b_data = 32'h11; b_last = 1;
    @(posedge clk); #1 b_data = 32'h22;
    check("b_ch1_valid", b_mvalid, 4'b0010);
    #1 check("b_ch1_stall", b_ready, 1'b0);
    @(posedge clk); #1 check("b_ch1_held", b_mdata[1], 32'h11);
    b_sel = 3; b_data = 32'h33;
    #1 check("b_ch3_ready", b_ready, 1'b1);
    @(posedge clk); #1 b_valid = 0;
    check("b_ch3_valid", b_mvalid, 4'b1010);
    check("b_ch3_data", b_mdata[3], 32'h33);
    check("b_ch1_still_held", b_mdata[1], 32'h11);
    b_mready = 4'hF;
    @(posedge clk); #1 check("b_all_drained", b_mvalid, 4'b0000);

`ifdef DEMUX_ROUTER_PKT_LOCK_EN
    // Packet locked to ch1 regardless of later sel values.
    for (int i = 0; i < 3; i++) begin
      b_valid = 1; b_sel = (i == 0) ? 2'd1 : (i == 1) ? 2'd0 : 2'd2;
      b_data = 32'h100 + i; b_last = (i == 2);
      @(posedge clk); #1;
      check("b_lock_ch1", b_mvalid, 4'b0010);
      check("b_lock_data", b_mdata[1], 32'h100 + i);
    end
    b_sel = 0; b_data = 32'h200; b_last = 1;
    @(posedge clk); #1 b_valid = 0;
    check("b_next_pkt_ch0", b_mvalid, 4'b0001);
    check("b_next_pkt_data", b_mdata[0], 32'h200);
`endif

    // Out-of-range beat on the N=3 instance is swallowed and counted.
    a_valid = 1; a_sel = 3; a_data = 32'h1234; a_last = 1;
    #1 check("a_drop_ready", a_ready, 1'b1);
    @(posedge clk); #1 a_valid = 0;
    check("a_drop_err", a_err, 1'b1);
    check("a_drop_cnt", a_cnt, 16'd1);
    check("a_drop_no_valid", a_mvalid, 3'b000);
    @(posedge clk); #1 check("a_err_one_cycle", a_err, 1'b0);

    // Random traffic, checked every cycle by the model.
    for (int i = 0; i < 3000; i++) begin
      a_valid  = ($urandom_range(0, 3) != 0);
      a_sel    = 2'($urandom_range(0, 3));
      a_data   = $urandom;
      a_last   = ($urandom_range(0, 3) == 0);
      a_mready = 3'($urandom_range(0, 7));
      @(posedge clk); #1;
    end

    // Close any open packet, drain, then fill ch0 and reset mid-packet.
    a_valid = 1; a_sel = 0; a_last = 1; a_mready = 3'b111;
    @(posedge clk); #1 a_valid = 0;
    @(posedge clk); #1;
    a_mready = 3'b000; a_valid = 1; a_sel = 0; a_data = 32'hC0FFEE; a_last = 0;
    @(posedge clk); #1 a_valid = 0;
    check("a_ch0_full", a_mvalid[0], 1'b1);
    rst = 1'b1;
    #1;
    check("a_async_rst_valid", a_mvalid, 3'b000);
    check("a_async_rst_data", a_mdata[0], 32'h0);
    check("a_async_rst_cnt", a_cnt, 16'h0);
    @(posedge clk); #1 rst = 1'b0;
    a_mready = 3'b111; a_valid = 1; a_sel = 0; a_data = 32'h5A; a_last = 1;
    @(posedge clk); #1 a_valid = 0;
    check("a_post_rst_valid", a_mvalid, 3'b001);
    check("a_post_rst_data", a_mdata[0], 32'h5A);

    // Drop counter saturation.
    a_valid = 1; a_sel = 3; a_last = 1;
    repeat (65536) @(posedge clk);
    #1 check("a_cnt_sat", a_cnt, 16'hFFFF);
    @(posedge clk); #1 a_valid = 0;
    check("a_cnt_stays_sat", a_cnt, 16'hFFFF);
    check("a_err_at_sat", a_err, 1'b1);
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux_router.md
DEMUX_ROUTER -- requirements
Module: demux_router

Interface
REQ-001 SHALL have parameter WIDTH, default 32, beat data width in bits.
REQ-002 SHALL have parameter N, default 4, number of output channels (N >= 2, need not be a power of 2).
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state on rising edge.
REQ-004 SHALL have port rst_i, input, 1, reset, asynchronous and active-high.
REQ-005 SHALL have port s_valid_i, input, 1, input beat valid.
REQ-006 SHALL have port s_ready_o, output, 1, input beat accepted when high with s_valid_i.
REQ-007 SHALL have port s_data_i, input, WIDTH, input beat data.
REQ-008 SHALL have port s_sel_i, input, $clog2(N), destination channel index.
REQ-009 SHALL have port s_last_i, input, 1, final beat of packet.
REQ-010 SHALL have port m_valid_o, output, N, per-channel output valid.
REQ-011 SHALL have port m_ready_i, input, N, per-channel output ready.
REQ-012 SHALL have port m_data_o, output, unpacked array [N] of WIDTH, per-channel data.
REQ-013 SHALL have port m_last_o, output, N, per-channel last flag.
REQ-014 SHALL have port err_o, output, 1, one-cycle pulse when a beat is dropped.
REQ-015 SHALL have port drop_cnt_o, output, 16, saturating count of dropped beats.

Function
REQ-016 SHALL hold one registered slot per channel; accepted beat appears on the destination channel the cycle after acceptance (latency 1); other channels are unaffected.
REQ-017 SHALL drive s_ready_o = 1 when destination d >= N, else ~m_valid_o[d] | m_ready_i[d] (combinational path from m_ready_i permitted).
REQ-018 SHALL load slot d with s_data_i/s_last_i and set m_valid_o[d] on accept; SHALL clear m_valid_o[d] on m_valid_o[d] & m_ready_i[d] with no load that cycle; simultaneous drain and load SHALL keep valid high with new data (full throughput).
REQ-019 SHALL hold m_data_o[d]/m_last_o[d] stable while m_valid_o[d] & ~m_ready_i[d].
REQ-020 SHALL, for d >= N, accept and discard the beat, pulse err_o next cycle, increment drop_cnt_o saturating at 16'hFFFF.
REQ-021 SHALL never de-assert s_ready_o for a blocked channel in a way that stalls a different, ready destination on a later beat (no head-of-line state beyond the current beat).

Reset
REQ-022 SHALL on rst_i high force immediately: m_valid_o=0, m_data_o=0, m_last_o=0, err_o=0, drop_cnt_o=0, FSM=IDLE; beats held in slots are lost.
REQ-023 SHALL accept no beat while rst_i is high (s_ready_o may be any value; acceptance is ignored).

Configuration
REQ-024 SHALL compile packet locking in when macro DEMUX_ROUTER_PKT_LOCK_EN is defined: FSM IDLE/LOCKED; accepted beat with s_last_i=0 in IDLE latches destination and enters LOCKED; in LOCKED s_sel_i is ignored and latched destination used; accepted beat with s_last_i=1 returns to IDLE; out-of-range first beat locks to drop for the whole packet, counting every beat.
REQ-025 SHALL, without DEMUX_ROUTER_PKT_LOCK_EN, route every beat by its own s_sel_i; no FSM; s_last_i only forwarded to m_last_o.

Structure
REQ-026 SHALL place the lock-state enum typedef (IDLE, LOCKED) and the drop-counter width constant (16) in shared package demux_router_pkg.
REQ-027 SHALL implement each channel slot as sub-module demux_slot (one-entry register slice with valid/ready), instantiated N times by generate.

Verification
REQ-028 Beat 0xA5A5A5A5, sel=2, m_ready_i=4'hF -> m_valid_o=4'b0100, m_data_o[2]=0xA5A5A5A5 one cycle later, others idle.
REQ-029 Back-to-back beats to ch1 with m_ready_i[1]=0 -> second beat stalls (s_ready_o=0), first data held; beat to ch3 next cycle is accepted.
REQ-030 N=3, sel=3, data 0x1234 -> s_ready_o=1, no m_valid_o, err_o pulse one cycle, drop_cnt_o 0->1; 65536 drops -> drop_cnt_o=0xFFFF.
REQ-031 With DEMUX_ROUTER_PKT_LOCK_EN: 3-beat packet, sel=1 on beat 0, sel=0/2 on beats 1/2, last on beat 2 -> all three on ch1; next packet sel=0 routes to ch0.
REQ-032 rst_i asserted mid-packet with ch0 slot full -> m_valid_o=0 same cycle without clock edge, FSM IDLE, drop_cnt_o=0; post-reset beat with sel=0 routes normally.
